// File: rtl/sdp_ram_reader_pkg.sv
// sdp_ram_reader_pkg: shared FSM encoding and parameter sanity check
package sdp_ram_reader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  function automatic bit fifo_depth_ok(input int depth, input int latency);
    return depth >= latency + 2 && (depth & (depth - 1)) == 0;
  endfunction
endpackage

// File: rtl/sdp_ram_reader_stream_fifo.sv
// stream_fifo: first-word-fall-through synchronous FIFO with occupancy count
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic wr, rd;
  assign rd = rd_en_i && !empty_o;
  assign wr = wr_en_i && (count_o != (AW+1)'(DEPTH) || rd);
  assign count_o = wptr_q - rptr_q;
  assign empty_o = wptr_q == rptr_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  // storage array, written at the tail
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  // pointers; simultaneous read and write leave occupancy unchanged even when full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(wr);
      rptr_q <= rptr_q + (AW+1)'(rd);
    end
endmodule

// File: rtl/sdp_ram_reader.sv
// sdp_ram_reader: sweeps a RAM address range and streams the read data with backpressure
module sdp_ram_reader import sdp_ram_reader_pkg::*; #(
  parameter int D_WIDTH    = 72,
  parameter int A_WIDTH    = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   length,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] ram_dout,
  output logic [D_WIDTH-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  if (!fifo_depth_ok(FIFO_DEPTH, LATENCY)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least LATENCY+2");
  end
  state_e state_q;
  logic [A_WIDTH-1:0] addr_q, r_addr_q;
  logic [A_WIDTH:0] iss_rem_q, out_rem_q, out_rem_d;
  logic [LATENCY:0] vld_q;
  logic done_q, issue, xfer, empty;
  logic [CW-1:0] occ;
  int credit;
  assign xfer = m_tvalid && m_tready;
  assign out_rem_d = out_rem_q - (A_WIDTH+1)'(xfer);
  // slots committed to FIFO or in flight; a word leaving this cycle frees its slot
  always_comb credit = int'(occ) + $countones(vld_q) - int'(xfer);
  assign issue = state_q == ISSUE && iss_rem_q != '0 && credit < FIFO_DEPTH;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign r_addr = r_addr_q;
  assign m_tvalid = !empty;
  assign m_tlast = m_tvalid && out_rem_q == (A_WIDTH+1)'(1);
  // command FSM, address/issue/output counters and in-flight valid pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      r_addr_q  <= '0;
      iss_rem_q <= '0;
      out_rem_q <= '0;
      vld_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      vld_q     <= {vld_q[LATENCY-1:0], issue};
      done_q    <= 1'b0;
      out_rem_q <= out_rem_d;
      if (issue) begin
        r_addr_q  <= addr_q;
        addr_q    <= addr_q + 1'b1;
        iss_rem_q <= iss_rem_q - 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          addr_q    <= base_addr;
          iss_rem_q <= length;
          out_rem_q <= length;
          if (length == '0) done_q <= 1'b1;
          else state_q <= ISSUE;
        end
        ISSUE: if (issue && iss_rem_q == (A_WIDTH+1)'(1)) state_q <= DRAIN;
        DRAIN: if (out_rem_d == '0) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  stream_fifo #(.WIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (vld_q[LATENCY]),
    .wr_data_i (ram_dout),
    .rd_en_i   (m_tready),
    .rd_data_o (m_tdata),
    .empty_o   (empty),
    .count_o   (occ)
  );
endmodule

// File: tb/tb_sdp_ram_reader.sv
// tb_sdp_ram_reader: directed bench with a behavioural RAM of matching latency
module tb_sdp_ram_reader;
  localparam int DW = 72, AW = 10, LAT = 2, FD = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, m_tready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] length = '0;
  logic busy, done, m_tvalid, m_tlast;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] ram_dout, m_tdata;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] stage [LAT];
  int cyc = 0, n_checks = 0, n_errs = 0;
  int first_vld, done_cnt, done_cyc, max_occ;
  bit busy_seen, stall_q;
  logic [DW-1:0] pdata;
  logic plast;
  logic [DW-1:0] dq[$];
  logic lq[$];
  int cq[$];

  sdp_ram_reader #(.D_WIDTH(DW), .A_WIDTH(AW), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .r_addr(r_addr), .ram_dout(ram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    stage[0] <= mem[r_addr];
    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
  end
  assign ram_dout = stage[LAT-1];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      dq.push_back(m_tdata);
      lq.push_back(m_tlast);
      cq.push_back(cyc);
    end
    if (m_tvalid && first_vld < 0) first_vld = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (int'(dut.u_fifo.count_o) > max_occ) max_occ = int'(dut.u_fifo.count_o);
    if (stall_q && m_tvalid) begin
      chk("stall_data_stable", 80'(m_tdata), 80'(pdata));
      chk("stall_last_stable", 80'(m_tlast), 80'(plast));
    end
    stall_q = m_tvalid && !m_tready;
    pdata = m_tdata;
    plast = m_tlast;
  end

  task automatic clear_mon();
    dq.delete();
    lq.delete();
    cq.delete();
    first_vld = -1;
    done_cnt = 0;
    done_cyc = -1;
    busy_seen = 1'b0;
    max_occ = 0;
  endtask

  task automatic start_cmd(input int b, input int n, output int s);
    @(posedge clk); #2;
    start = 1'b1;
    base_addr = b[AW-1:0];
    length = n[AW:0];
    s = cyc + 1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      @(negedge clk); #1;
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    chk({tag, "_done_pulses"}, 80'(done_cnt), 80'(1));
  endtask

  task automatic check_stream(input string tag, input int b, input int n);
    chk({tag, "_word_count"}, 80'(dq.size()), 80'(n));
    for (int i = 0; i < n && i < dq.size(); i++) begin
      chk({tag, "_data"}, 80'(dq[i]), 80'((b + i) % (1 << AW)));
      chk({tag, "_last"}, 80'(lq[i]), 80'(i == n - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 80'(busy), 80'(0));
    chk({tag, "_done"}, 80'(done), 80'(0));
    chk({tag, "_r_addr"}, 80'(r_addr), 80'(0));
    chk({tag, "_tvalid"}, 80'(m_tvalid), 80'(0));
    chk({tag, "_tlast"}, 80'(m_tlast), 80'(0));
    chk({tag, "_tdata"}, 80'(m_tdata), 80'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    for (int i = 0; i < LAT; i++) stage[i] = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("reset");

    m_tready = 1'b1;
    clear_mon();
    start_cmd(5, 8, s);
    wait_done("basic");
    chk("basic_first_valid_cycle", 80'(first_vld), 80'(s + LAT + 2));
    check_stream("basic", 5, 8);
    for (int i = 0; i < 8 && i < cq.size(); i++) chk("basic_xfer_cycle", 80'(cq[i]), 80'(s + LAT + 2 + i));
    chk("basic_done_cycle", 80'(done_cyc), 80'(s + LAT + 2 + 8));
    chk("basic_busy_after", 80'(busy), 80'(0));

    clear_mon();
    start_cmd(1020, 8, s);
    wait_done("wrap");
    check_stream("wrap", 1020, 8);
    for (int i = 0; i < 8 && i < cq.size(); i++) chk("wrap_xfer_cycle", 80'(cq[i]), 80'(s + LAT + 2 + i));

    clear_mon();
    start_cmd(100, 6, s);
    for (int i = 0; i < 40; i++) begin
      m_tready = (i >= 5 && i < 15) ? 1'b0 : (i % 2 == 0);
      @(posedge clk); #2;
    end
    m_tready = 1'b1;
    wait_done("bp");
    check_stream("bp", 100, 6);
    chk("bp_occupancy_within_depth", 80'(max_occ <= FD), 80'(1));

    clear_mon();
    start_cmd(7, 0, s);
    repeat (6) begin
      @(negedge clk); #1;
    end
    chk("zero_done_pulses", 80'(done_cnt), 80'(1));
    chk("zero_done_cycle", 80'(done_cyc), 80'(s));
    chk("zero_busy_seen", 80'(busy_seen), 80'(0));
    chk("zero_valid_seen", 80'(first_vld), 80'(-1));
    chk("zero_word_count", 80'(dq.size()), 80'(0));

    clear_mon();
    start_cmd(200, 5, s);
    repeat (2) @(posedge clk);
    #2;
    start = 1'b1;
    base_addr = 10'd50;
    length = 11'd3;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("restart");
    check_stream("restart", 200, 5);

    clear_mon();
    m_tready = 1'b0;
    start_cmd(300, 8, s);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    chk("midreset_word_count", 80'(dq.size()), 80'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    m_tready = 1'b1;
    clear_mon();
    start_cmd(0, 4, s);
    wait_done("post_reset");
    check_stream("post_reset", 0, 4);
    chk("post_reset_first_valid_cycle", 80'(first_vld), 80'(s + LAT + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
